// File: rtl/beam_sweep_pkg.sv
// Shared types and constants for the beam sweep controller.
// Holds the FSM state type and the default -60..+60 degree steering table.
package beam_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // Beamformer output is offset-binary; this is its zero level.
    localparam logic [15:0] DC_OFFSET = 16'h8000;

    // 16 angles, 8 degree steps, -60..+60; sin scaled by 2^16 (17 bits).
    localparam int TBL_N = 16;
    localparam int TBL_W = 17;

    localparam logic [TBL_W-1:0] SIN_TBL [TBL_N] = '{
        17'd56756, 17'd51643, 17'd45525, 17'd38521,
        17'd30767, 17'd22415, 17'd13626, 17'd4572,
        17'd4572,  17'd13626, 17'd22415, 17'd30767,
        17'd38521, 17'd45525, 17'd51643, 17'd56756
    };

    // Bit i set means entry i steers to the negative side.
    localparam logic [TBL_N-1:0] SIGN_TBL = 16'h00FF;

    // Spread n sweep indices evenly over the table, rounding to nearest.
    function automatic int tbl_pos(input int idx, input int n);
        int p;
        p = (idx * (TBL_N - 1) + (n - 1) / 2) / (n - 1);
        if (p > TBL_N - 1) begin
            p = TBL_N - 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/beam_sweep_controller_angle_lut.sv
// Combinational steering ROM: sweep index -> {sign_bit, sin_theta}.
// Table entries are rescaled to the beamformer's SIN_WIDTH.
module angle_lut
    import beam_sweep_pkg::*;
#(
    parameter int NUM_ANGLES = 16,
    parameter int SIN_WIDTH  = 17
) (
    input  logic [$clog2(NUM_ANGLES)-1:0] idx_i,
    output logic                          sign_o,
    output logic [SIN_WIDTH-1:0]          sin_o
);

    logic [3:0]       pos;
    logic [TBL_W-1:0] raw;

    // Table lookup for the selected sweep position.
    always_comb begin
        pos    = 4'(tbl_pos(int'(idx_i), NUM_ANGLES));
        raw    = SIN_TBL[pos];
        sign_o = SIGN_TBL[pos];
    end

    if (SIN_WIDTH == TBL_W) begin : g_eq
        assign sin_o = raw;
    end else if (SIN_WIDTH > TBL_W) begin : g_wide
        assign sin_o = {raw, {(SIN_WIDTH - TBL_W){1'b0}}};
    end else begin : g_narrow
        assign sin_o = raw[TBL_W-1 -: SIN_WIDTH];
    end

endmodule

// File: rtl/beam_sweep_controller.sv
// Steers the beamformer through the angle table and reports peak energy.
// Define BEAM_SWEEP_CONTINUOUS_EN to restart the sweep after each result.
module beam_sweep_controller
    import beam_sweep_pkg::*;
#(
    parameter int NUM_ANGLES     = 16,
    parameter int SIN_WIDTH      = 17,
    parameter int SETTLE_SAMPLES = 80,
    parameter int DWELL_SAMPLES  = 256,
    parameter int ENERGY_WIDTH   = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic                          abort_in,
    input  logic                          sample_valid_in,
    input  logic [15:0]                   beam_sample_in,
    output logic [SIN_WIDTH-1:0]          sin_theta_out,
    output logic                          sign_bit_out,
    output logic [$clog2(NUM_ANGLES)-1:0] angle_index_out,
    output logic                          busy_out,
    output logic                          sweep_done_out,
    output logic [$clog2(NUM_ANGLES)-1:0] peak_index_out,
    output logic [ENERGY_WIDTH-1:0]       peak_energy_out
);

    localparam int IDX_W = $clog2(NUM_ANGLES);
    localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int DWL_W = $clog2(DWELL_SAMPLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ANGLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_SAMPLES - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL_SAMPLES - 1);
    localparam logic [ENERGY_WIDTH-1:0] ACC_MAX = '1;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SET_W-1:0]        set_cnt_q;
    logic [DWL_W-1:0]        dwl_cnt_q;
    logic [ENERGY_WIDTH-1:0] acc_q;
    logic [IDX_W-1:0]        wpk_idx_q;
    logic [ENERGY_WIDTH-1:0] wpk_e_q;
    logic [IDX_W-1:0]        pk_idx_q;
    logic [ENERGY_WIDTH-1:0] pk_e_q;
    logic                    done_q;
    logic                    busy_q;
    logic [SIN_WIDTH-1:0]    sin_q;
    logic                    sign_q;

    logic signed [16:0]      diff;
    logic [15:0]             mag;
    logic [ENERGY_WIDTH:0]   sum;
    logic [ENERGY_WIDTH-1:0] acc_d;
    logic [IDX_W-1:0]        lut_idx_d;
    logic [SIN_WIDTH-1:0]    lut_sin;
    logic                    lut_sign;

    // Reset forces the table lookup to entry 0 so steering resets there.
    assign lut_idx_d = rst_in ? '0 : idx_q;

    angle_lut #(
        .NUM_ANGLES(NUM_ANGLES),
        .SIN_WIDTH (SIN_WIDTH)
    ) u_lut (
        .idx_i (lut_idx_d),
        .sign_o(lut_sign),
        .sin_o (lut_sin)
    );

    // Remove DC offset, rectify, and add to accumulator with saturation.
    always_comb begin
        diff  = $signed({1'b0, beam_sample_in}) - $signed({1'b0, DC_OFFSET});
        mag   = diff[16] ? 16'(-diff) : diff[15:0];
        sum   = {1'b0, acc_q} + (ENERGY_WIDTH + 1)'(mag);
        acc_d = sum[ENERGY_WIDTH] ? ACC_MAX : sum[ENERGY_WIDTH-1:0];
    end

    // Sweep sequencer with registered steering and result outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            set_cnt_q <= '0;
            dwl_cnt_q <= '0;
            acc_q     <= '0;
            wpk_idx_q <= '0;
            wpk_e_q   <= '0;
            pk_idx_q  <= '0;
            pk_e_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sin_q     <= lut_sin;
            sign_q    <= lut_sign;
        end else begin
            sin_q  <= lut_sin;
            sign_q <= lut_sign;
            done_q <= 1'b0;
            if (abort_in && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_in) begin
                            idx_q     <= '0;
                            set_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (sample_valid_in) begin
                            if (set_cnt_q == SET_LAST) begin
                                acc_q     <= '0;
                                dwl_cnt_q <= '0;
                                state_q   <= ST_DWELL;
                            end else begin
                                set_cnt_q <= set_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_DWELL: begin
                        if (sample_valid_in) begin
                            acc_q <= acc_d;
                            if (dwl_cnt_q == DWL_LAST) begin
                                state_q <= ST_COMPARE;
                            end else begin
                                dwl_cnt_q <= dwl_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_COMPARE: begin
                        if (idx_q == '0 || acc_q > wpk_e_q) begin
                            wpk_idx_q <= idx_q;
                            wpk_e_q   <= acc_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            set_cnt_q <= '0;
                            state_q   <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        pk_idx_q <= wpk_idx_q;
                        pk_e_q   <= wpk_e_q;
                        done_q   <= 1'b1;
`ifdef BEAM_SWEEP_CONTINUOUS_EN
                        idx_q     <= '0;
                        set_cnt_q <= '0;
                        state_q   <= ST_SETTLE;
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sin_theta_out   = sin_q;
    assign sign_bit_out    = sign_q;
    assign angle_index_out = idx_q;
    assign busy_out        = busy_q;
    assign sweep_done_out  = done_q;
    assign peak_index_out  = pk_idx_q;
    assign peak_energy_out = pk_e_q;

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Directed bench for beam_sweep_controller (4 angles, 2 settle, 4 dwell).
// A second instance with a 17-bit accumulator exercises saturation.
module tb_beam_sweep_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        abort = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] beam = 16'h8000;
    logic [15:0] beam2 = 16'h0000;

    logic [16:0] sin1, sin2;
    logic        sign1, sign2;
    logic [1:0]  ang1, ang2;
    logic        busy1, busy2;
    logic        done1, done2;
    logic [1:0]  pki1, pki2;
    logic [31:0] pke1;
    logic [16:0] pke2;

    int n_chk = 0;
    int n_fail = 0;
    int strobes = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int strobes_at_done = 0;

    logic [15:0] samp [24];
    int gaps [8] = '{1, 3, 7, 2, 5, 1, 4, 6};

    always #5 clk = ~clk;

    beam_sweep_controller #(
        .NUM_ANGLES(4), .SIN_WIDTH(17), .SETTLE_SAMPLES(2),
        .DWELL_SAMPLES(4), .ENERGY_WIDTH(32)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start1),
        .abort_in(abort), .sample_valid_in(valid),
        .beam_sample_in(beam), .sin_theta_out(sin1),
        .sign_bit_out(sign1), .angle_index_out(ang1),
        .busy_out(busy1), .sweep_done_out(done1),
        .peak_index_out(pki1), .peak_energy_out(pke1)
    );

    beam_sweep_controller #(
        .NUM_ANGLES(4), .SIN_WIDTH(17), .SETTLE_SAMPLES(2),
        .DWELL_SAMPLES(4), .ENERGY_WIDTH(17)
    ) dut_sat (
        .clk_in(clk), .rst_in(rst), .start_in(start2),
        .abort_in(1'b0), .sample_valid_in(valid),
        .beam_sample_in(beam2), .sin_theta_out(sin2),
        .sign_bit_out(sign2), .angle_index_out(ang2),
        .busy_out(busy2), .sweep_done_out(done2),
        .peak_index_out(pki2), .peak_energy_out(pke2)
    );

    always @(negedge clk) begin
        if (valid) strobes++;
        if (done1) begin
            done_cnt1++;
            strobes_at_done = strobes;
        end
        if (done2) done_cnt2++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v[4], input bit junk);
        for (int a = 0; a < 4; a++) begin
            for (int j = 0; j < 6; j++) begin
                samp[a*6+j] = (junk && j < 2) ? 16'h83E8 : v[a];
            end
        end
    endtask

    task automatic run(input int k0, input int k1, input bit irr);
        for (int k = k0; k < k1; k++) begin
            repeat (irr ? gaps[k%8] : 99) tick();
            valid = 1'b1;
            beam  = samp[k];
            tick();
            valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int which, input int base,
                             input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            got = (which == 1) ? done_cnt1 : done_cnt2;
            if (got > base) break;
        end
        chk("done_seen", 64'(got > base), 64'd1);
    endtask

    logic [15:0] v[4];
    int d0;
    int s0;

    initial begin
        repeat (5) tick();
        rst = 1'b0;
        repeat (50) tick();
        @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_angle", ang1, 0);
        chk("rst_pk_idx", pki1, 0);
        chk("rst_pk_e", pke1, 0);
        chk("rst_sin", sin1, 56756);
        chk("rst_sign", sign1, 1);

        // sweep A: energies 40,200,120,80
        v = '{16'h800A, 16'h8032, 16'h801E, 16'h8014};
        fill(v, 1'b0);
        d0 = done_cnt1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        @(negedge clk);
        chk("a_busy", busy1, 1);
        run(0, 9, 1'b0);
        @(negedge clk);
        chk("a_ang1", ang1, 1);
        chk("a_sin1", sin1, 22415);
        chk("a_sign1", sign1, 1);
        run(9, 24, 1'b0);
        wait_done(1, d0, 50);
        chk("a_pk_idx", pki1, 1);
        chk("a_pk_e", pke1, 200);
        repeat (5) tick();
        @(negedge clk);
        chk("a_one_pulse", done_cnt1, d0 + 1);
        chk("a_idle", busy1, 0);
        chk("a_ang_last", ang1, 3);
        chk("a_sin_last", sin1, 56756);
        chk("a_sign_last", sign1, 0);

        // sweep B: -50 and +50 tie at 200, lower index kept
        v = '{16'h800A, 16'h7FCE, 16'h8032, 16'h8014};
        fill(v, 1'b0);
        d0 = done_cnt1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run(0, 24, 1'b0);
        wait_done(1, d0, 50);
        chk("b_pk_idx", pki1, 1);
        chk("b_pk_e", pke1, 200);

        // irregular gaps, settle samples are large junk
        v = '{16'h8005, 16'h8009, 16'h8003, 16'h8006};
        fill(v, 1'b1);
        d0 = done_cnt1;
        s0 = strobes;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run(0, 24, 1'b1);
        wait_done(1, d0, 50);
        chk("irr_strobes", strobes_at_done - s0, 24);
        chk("irr_pk_idx", pki1, 1);
        chk("irr_pk_e", pke1, 36);

        // abort in angle 2 dwell; start while busy ignored
        v = '{16'h8064, 16'h80C8, 16'h812C, 16'h8190};
        fill(v, 1'b0);
        d0 = done_cnt1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run(0, 15, 1'b1);
        @(negedge clk);
        chk("ab_ang2", ang1, 2);
        chk("ab_busy", busy1, 1);
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        @(negedge clk);
        chk("ab_start_ign", ang1, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("ab_idle", busy1, 0);
        chk("ab_ang0", ang1, 0);
        repeat (10) tick();
        @(negedge clk);
        chk("ab_no_done", done_cnt1, d0);
        chk("ab_pk_idx", pki1, 1);
        chk("ab_pk_e", pke1, 36);
        chk("ab_sin0", sin1, 56756);

        // saturation: 4 x 32768 exceeds 17 bits
        d0 = done_cnt2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        run(0, 24, 1'b1);
        wait_done(2, d0, 50);
        chk("sat_pk_e", pke2, 131071);
        chk("sat_pk_idx", pki2, 0);

        // reset mid-sweep clears results
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run(0, 8, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy1, 0);
        chk("mrst_ang", ang1, 0);
        chk("mrst_pk_idx", pki1, 0);
        chk("mrst_pk_e", pke1, 0);
        chk("mrst_sin", sin1, 56756);
        chk("mrst_sign", sign1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
